// File: rtl/game_ctrl_if.sv
// Handshake bundle between the Minesweeper menu/board logic and the game controller.
// The master side drives the requests; the slave side (the controller) returns status and setup.
interface game_ctrl_if #(
   parameter int N_LEVELS = 3,
   parameter int LVL_W    = 3,
   parameter int ROW_W    = 5,
   parameter int MINE_W   = 7,
   parameter int TIMER_W  = 10,
   parameter int CNT_W    = 8
);
   logic [LVL_W-1:0]          level_sel;
   logic                      tick_1s;
   logic                      pause_req;
   logic                      game_won;
   logic                      game_lost;
   logic                      retry;

   logic [2:0]                state_out;
   logic [LVL_W-1:0]          level_idx;
   logic [ROW_W-1:0]          rows;
   logic [MINE_W-1:0]         mines;
   logic [TIMER_W-1:0]        time_left;
   logic                      timeout;
   logic [N_LEVELS*CNT_W-1:0] won_cnt;
   logic [N_LEVELS*CNT_W-1:0] lost_cnt;

   modport master (
      output level_sel, tick_1s, pause_req, game_won, game_lost, retry,
      input  state_out, level_idx, rows, mines, time_left, timeout, won_cnt, lost_cnt
   );

   modport slave (
      input  level_sel, tick_1s, pause_req, game_won, game_lost, retry,
      output state_out, level_idx, rows, mines, time_left, timeout, won_cnt, lost_cnt
   );
endinterface

// File: rtl/game_ctrl_fsm.sv
// Parametrised Minesweeper game controller: level setup from tables, game sequencing,
// per-game countdown with timeout loss, and saturating per-level win/loss statistics.
module game_ctrl_fsm #(
   parameter int N_LEVELS = 3,
   parameter int LVL_W    = 3,
   parameter int ROW_W    = 5,
   parameter int MINE_W   = 7,
   parameter int TIMER_W  = 10,
   parameter int CNT_W    = 8,
   parameter logic [N_LEVELS*ROW_W-1:0]   ROWS_TBL  = {5'd16, 5'd12, 5'd8},
   parameter logic [N_LEVELS*MINE_W-1:0]  MINES_TBL = {7'd40, 7'd20, 7'd10},
   parameter logic [N_LEVELS*TIMER_W-1:0] TIMER_TBL = {10'd999, 10'd300, 10'd0}
) (
   input logic         clk,
   input logic         rst,
   game_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      MENU      = 3'd0,
      PLAY      = 3'd1,
      PAUSE     = 3'd2,
      WIN       = 3'd3,
      LOST      = 3'd4,
      GAME_OVER = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0]   CNT_MAX = '1;
   localparam logic [TIMER_W-1:0] ONE_SEC = TIMER_W'(1);

   state_t                    state;
   logic [2:0]                state_q;
   logic [LVL_W-1:0]          level_q;
   logic [ROW_W-1:0]          rows_q;
   logic [MINE_W-1:0]         mines_q;
   logic [TIMER_W-1:0]        time_q;
   logic                      timed_q;
   logic                      timeout_q;
   logic [N_LEVELS*CNT_W-1:0] won_q;
   logic [N_LEVELS*CNT_W-1:0] lost_q;

   logic                      sel_ok;
   logic [ROW_W-1:0]          sel_rows;
   logic [MINE_W-1:0]         sel_mines;
   logic [TIMER_W-1:0]        sel_limit;

   // Table lookup for the requested level; a selection outside 1..N_LEVELS is not valid.
   always_comb begin
      // NOTE: every signal gets a default before the loop so no latch is inferred.
      sel_ok    = 1'b0;
      sel_rows  = '0;
      sel_mines = '0;
      sel_limit = '0;
      for (int k = 0; k < N_LEVELS; k++) begin
         if (bus.level_sel == LVL_W'(k + 1)) begin
            sel_ok    = 1'b1;
            sel_rows  = ROWS_TBL[k*ROW_W +: ROW_W];
            sel_mines = MINES_TBL[k*MINE_W +: MINE_W];
            sel_limit = TIMER_TBL[k*TIMER_W +: TIMER_W];
         end
      end
   end

   // NOTE: all state here updates with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= MENU;
         state_q   <= 3'd0;
         level_q   <= '0;
         rows_q    <= '0;
         mines_q   <= '0;
         time_q    <= '0;
         timed_q   <= 1'b0;
         timeout_q <= 1'b0;
         won_q     <= '0;
         lost_q    <= '0;
      end else begin
         state_q <= state;
         case (state)
            MENU: begin
               if (sel_ok) begin
                  state     <= PLAY;
                  level_q   <= bus.level_sel;
                  rows_q    <= sel_rows;
                  mines_q   <= sel_mines;
                  time_q    <= sel_limit;
                  timed_q   <= (sel_limit != '0);
                  timeout_q <= 1'b0;
               end
            end
            PLAY: begin
               if (bus.game_lost) begin
                  state <= LOST;
               end else if (bus.game_won) begin
                  state <= WIN;
               end else if (timed_q && bus.tick_1s && time_q == ONE_SEC) begin
                  state     <= LOST;
                  time_q    <= '0;
                  timeout_q <= 1'b1;
               end else if (bus.pause_req) begin
                  state <= PAUSE;
               end else if (timed_q && bus.tick_1s && time_q > ONE_SEC) begin
                  time_q <= time_q - ONE_SEC;
               end
            end
            PAUSE: begin
               if (!bus.pause_req) state <= PLAY;
            end
            WIN: begin
               state <= GAME_OVER;
               for (int k = 0; k < N_LEVELS; k++) begin
                  if (level_q == LVL_W'(k + 1) && won_q[k*CNT_W +: CNT_W] != CNT_MAX)
                     won_q[k*CNT_W +: CNT_W] <= won_q[k*CNT_W +: CNT_W] + CNT_W'(1);
               end
            end
            LOST: begin
               state <= GAME_OVER;
               for (int k = 0; k < N_LEVELS; k++) begin
                  if (level_q == LVL_W'(k + 1) && lost_q[k*CNT_W +: CNT_W] != CNT_MAX)
                     lost_q[k*CNT_W +: CNT_W] <= lost_q[k*CNT_W +: CNT_W] + CNT_W'(1);
               end
            end
            GAME_OVER: begin
               // timeout stays visible in the menu until the next game starts.
               if (bus.retry) begin
                  state   <= MENU;
                  level_q <= '0;
                  rows_q  <= '0;
                  mines_q <= '0;
                  time_q  <= '0;
                  timed_q <= 1'b0;
               end
            end
            default: begin
               state   <= MENU;
               level_q <= '0;
               rows_q  <= '0;
               mines_q <= '0;
               time_q  <= '0;
               timed_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.state_out = state_q;
   assign bus.level_idx = level_q;
   assign bus.rows      = rows_q;
   assign bus.mines     = mines_q;
   assign bus.time_left = time_q;
   assign bus.timeout   = timeout_q;
   assign bus.won_cnt   = won_q;
   assign bus.lost_cnt  = lost_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm: default-parameter instance plus a CNT_W=2 instance for saturation.
module tb_game_ctrl_fsm;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   game_ctrl_if                 bus ();
   game_ctrl_if #(.CNT_W(2))    bus_s ();

   game_ctrl_fsm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   game_ctrl_fsm #(.CNT_W(2)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (bus_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic cycle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick_1s = 1'b1;
         cycle(1);
         bus.tick_1s = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.level_sel = '0; bus.tick_1s = 0; bus.pause_req = 0;
      bus.game_won = 0; bus.game_lost = 0; bus.retry = 0;
      bus_s.level_sel = '0; bus_s.tick_1s = 0; bus_s.pause_req = 0;
      bus_s.game_won = 0; bus_s.game_lost = 0; bus_s.retry = 0;

      // Reset values
      cycle(2);
      check("rst_state", 32'(bus.state_out), 0);
      check("rst_level", 32'(bus.level_idx), 0);
      check("rst_rows", 32'(bus.rows), 0);
      check("rst_mines", 32'(bus.mines), 0);
      check("rst_time", 32'(bus.time_left), 0);
      check("rst_timeout", 32'(bus.timeout), 0);
      check("rst_won", 32'(bus.won_cnt), 0);
      check("rst_lost", 32'(bus.lost_cnt), 0);
      rst = 1'b0;

      // Out-of-range and empty selections stay in MENU
      bus.level_sel = 3'd4;
      cycle(2);
      check("sel4_state", 32'(bus.state_out), 0);
      check("sel4_level", 32'(bus.level_idx), 0);
      check("sel4_rows", 32'(bus.rows), 0);
      check("sel4_time", 32'(bus.time_left), 0);
      bus.level_sel = 3'd0;
      cycle(2);
      check("sel0_state", 32'(bus.state_out), 0);
      check("sel0_mines", 32'(bus.mines), 0);

      // Level 1: unlimited timer
      bus.level_sel = 3'd1;
      cycle(1);
      bus.level_sel = 3'd0;
      check("l1_state_lag", 32'(bus.state_out), 0);
      check("l1_level", 32'(bus.level_idx), 1);
      check("l1_rows", 32'(bus.rows), 8);
      check("l1_mines", 32'(bus.mines), 10);
      check("l1_time", 32'(bus.time_left), 0);
      cycle(1);
      check("l1_state_play", 32'(bus.state_out), 1);
      tick(5);
      check("l1_time_held", 32'(bus.time_left), 0);
      check("l1_still_play", 32'(bus.state_out), 1);
      bus.game_won = 1'b1;
      cycle(1);
      bus.game_won = 1'b0;
      cycle(1);
      check("l1_won", 32'(bus.won_cnt), 32'h00_00_01);
      bus.retry = 1'b1;
      cycle(1);
      bus.retry = 1'b0;
      check("l1_menu_level", 32'(bus.level_idx), 0);
      check("l1_menu_rows", 32'(bus.rows), 0);
      cycle(1);
      check("l1_menu_state", 32'(bus.state_out), 0);

      // Level 2: countdown to timeout
      bus.level_sel = 3'd2;
      cycle(1);
      bus.level_sel = 3'd0;
      check("l2_time_load", 32'(bus.time_left), 300);
      check("l2_rows", 32'(bus.rows), 12);
      tick(299);
      check("l2_time_1", 32'(bus.time_left), 1);
      check("l2_state_play", 32'(bus.state_out), 1);
      check("l2_timeout_pre", 32'(bus.timeout), 0);
      tick(1);
      check("l2_time_0", 32'(bus.time_left), 0);
      check("l2_timeout", 32'(bus.timeout), 1);
      cycle(1);
      check("l2_state_lost", 32'(bus.state_out), 4);
      check("l2_lost_cnt", 32'(bus.lost_cnt), 32'h00_01_00);
      cycle(1);
      check("l2_state_over", 32'(bus.state_out), 5);
      check("l2_over_timeout", 32'(bus.timeout), 1);
      bus.retry = 1'b1;
      cycle(1);
      bus.retry = 1'b0;

      // Level 3: pause freezes time and ignores board events
      bus.level_sel = 3'd3;
      cycle(1);
      bus.level_sel = 3'd0;
      check("l3_timeout_clr", 32'(bus.timeout), 0);
      check("l3_time_load", 32'(bus.time_left), 999);
      check("l3_mines", 32'(bus.mines), 40);
      bus.pause_req = 1'b1;
      cycle(1);
      tick(10);
      check("l3_pause_state", 32'(bus.state_out), 2);
      check("l3_pause_time", 32'(bus.time_left), 999);
      bus.game_lost = 1'b1;
      cycle(1);
      bus.game_lost = 1'b0;
      cycle(1);
      check("l3_pause_ignore", 32'(bus.state_out), 2);
      bus.pause_req = 1'b0;
      cycle(2);
      check("l3_resume", 32'(bus.state_out), 1);
      tick(1);
      check("l3_time_dec", 32'(bus.time_left), 998);
      bus.game_won = 1'b1;
      cycle(1);
      bus.game_won = 1'b0;
      cycle(1);
      check("l3_state_win", 32'(bus.state_out), 3);
      cycle(1);
      check("l3_state_over", 32'(bus.state_out), 5);
      check("l3_won_cnt", 32'(bus.won_cnt), 32'h01_00_01);
      bus.retry = 1'b1;
      cycle(1);
      bus.retry = 1'b0;

      // Simultaneous won+lost+tick: loss wins, no decrement
      bus.level_sel = 3'd2;
      cycle(1);
      bus.level_sel = 3'd0;
      bus.tick_1s = 1'b1; bus.game_won = 1'b1; bus.game_lost = 1'b1;
      cycle(1);
      bus.tick_1s = 1'b0; bus.game_won = 1'b0; bus.game_lost = 1'b0;
      check("both_time", 32'(bus.time_left), 300);
      cycle(1);
      check("both_state_lost", 32'(bus.state_out), 4);
      check("both_lost_cnt", 32'(bus.lost_cnt), 32'h00_02_00);
      check("both_won_cnt", 32'(bus.won_cnt), 32'h01_00_01);
      bus.retry = 1'b1;
      cycle(1);
      bus.retry = 1'b0;

      // CNT_W=2 instance: saturation at 3
      for (int g = 0; g < 5; g++) begin
         bus_s.level_sel = 3'd1;
         cycle(1);
         bus_s.level_sel = 3'd0;
         bus_s.game_won = 1'b1;
         cycle(1);
         bus_s.game_won = 1'b0;
         cycle(1);
         check("sat_won", 32'(bus_s.won_cnt), (g < 3) ? 32'(g + 1) : 32'd3);
         bus_s.retry = 1'b1;
         cycle(1);
         bus_s.retry = 1'b0;
      end
      cycle(1);
      check("sat_menu_state", 32'(bus_s.state_out), 0);
      check("sat_retained", 32'(bus_s.won_cnt), 32'd3);

      // Reset in the middle of a game
      bus_s.level_sel = 3'd3;
      cycle(1);
      bus_s.level_sel = 3'd0;
      cycle(1);
      check("mid_play", 32'(bus_s.state_out), 1);
      check("mid_time", 32'(bus_s.time_left), 999);
      rst = 1'b1;
      cycle(1);
      rst = 1'b0;
      check("mrst_state", 32'(bus_s.state_out), 0);
      check("mrst_level", 32'(bus_s.level_idx), 0);
      check("mrst_rows", 32'(bus_s.rows), 0);
      check("mrst_mines", 32'(bus_s.mines), 0);
      check("mrst_time", 32'(bus_s.time_left), 0);
      check("mrst_timeout", 32'(bus_s.timeout), 0);
      check("mrst_won", 32'(bus_s.won_cnt), 0);
      check("mrst_lost", 32'(bus_s.lost_cnt), 0);
      cycle(2);
      check("mrst_stay_menu", 32'(bus_s.state_out), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/game_ctrl_fsm.md
Name: game_ctrl_fsm

Overview:
- Parametrised top-level game controller for the Minesweeper design; supersedes the fixed three-level controller.
- Takes the level choice from the menu logic. Loads that level's board and timer setup from parameter tables.
- Sequences MENU/PLAY/PAUSE/WIN/LOST/GAME_OVER, runs the per-game countdown, and declares a loss on timeout.
- Keeps saturating won/lost statistics per level for the display and UART stats blocks.

Parameters:
- N_LEVELS, 3: number of selectable levels, 1..7.
- LVL_W, 3: width of level_sel; level_sel 0 means no selection.
- ROW_W, 5: width of the row/column count field.
- MINE_W, 7: width of the mine count field.
- TIMER_W, 10: width of the timer seconds field.
- CNT_W, 8: width of each statistics counter.
- ROWS_TBL, {5'd16,5'd12,5'd8}: packed N_LEVELS*ROW_W vector; level k occupies slice k-1.
- MINES_TBL, {7'd40,7'd20,7'd10}: packed N_LEVELS*MINE_W vector of mine counts.
- TIMER_TBL, {10'd999,10'd300,10'd0}: packed N_LEVELS*TIMER_W vector of time limits; 0 means no time limit.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, synchronous, active-high.
- level_sel, in, LVL_W: requested level, sampled in MENU.
- tick_1s, in, 1: one-cycle pulse per second.
- pause_req, in, 1: level-sensitive pause request.
- game_won, in, 1: board logic reports all safe fields opened.
- game_lost, in, 1: board logic reports a mine opened.
- retry, in, 1: return to menu from GAME_OVER.
- state_out, out, 3: MENU=0, PLAY=1, PAUSE=2, WIN=3, LOST=4, GAME_OVER=5.
- level_idx, out, LVL_W: active level; 0 in MENU.
- rows, out, ROW_W: active row/column count.
- mines, out, MINE_W: active mine count.
- time_left, out, TIMER_W: remaining seconds, or the time limit value when unlimited.
- timeout, out, 1: sticky flag; set when the last game was lost by timer.
- won_cnt, out, N_LEVELS*CNT_W: per-level wins; slice k-1 holds level k.
- lost_cnt, out, N_LEVELS*CNT_W: per-level losses, same slicing.

Behaviour:
- All outputs are registered.
- Reset values:
  - state and state_out = MENU.
  - level_idx, rows, mines, time_left, timeout = 0.
  - All counters = 0.
- state_out equals the internal state delayed by one cycle, so consumers see a transition one cycle after it is taken.
- MENU:
  - Setup outputs are held at 0.
  - If 1 <= level_sel <= N_LEVELS, next state is PLAY.
  - On that same edge, load level_idx=level_sel, rows/mines/time_left from the tables, and clear timeout.
  - level_sel = 0 or level_sel > N_LEVELS: stay in MENU, outputs unchanged.
- PLAY, priority order:
  1. game_lost -> LOST.
  2. game_won -> WIN.
  3. Timeout: limit nonzero, tick_1s=1 and time_left==1. time_left becomes 0, timeout is set, next state is LOST.
  4. pause_req -> PAUSE.
  5. Otherwise, if tick_1s and the limit is nonzero and time_left > 1, time_left decrements by 1.
- game_won and game_lost asserted together -> LOST.
- A tick in the same cycle as a won or lost event does not decrement time_left.
- Unlimited level (table value 0): time_left is held and no timeout can occur.
- PAUSE:
  - time_left is frozen and tick_1s is ignored.
  - game_won and game_lost are ignored.
  - When pause_req deasserts, return to PLAY.
- WIN: increment won_cnt slice level_idx-1, then go to GAME_OVER unconditionally (1 cycle).
- LOST: same as WIN, but on lost_cnt.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- GAME_OVER:
  - Setup outputs, time_left and timeout are held.
  - retry -> MENU; the setup outputs clear on the MENU-entry edge.
- Counters are cleared only by rst; retry and the menu do not touch them.
- Illegal state encoding -> MENU on the next edge.
- rst asserted mid-game overrides every input; all outputs are back at reset values after one edge.
- The design does not depend on any tick_1s duty cycle beyond a single-cycle pulse.

Test Plan:
- Reset, then level_sel=1 for one cycle.
  - state_out=PLAY two edges later.
  - rows=8, mines=10, time_left=0; time_left stays 0 across 5 ticks.
- level_sel=2, drive 299 ticks.
  - time_left=1.
  - One more tick -> LOST, timeout=1, lost_cnt[1]=1, then GAME_OVER.
- level_sel=3, pause_req=1 for 10 ticks, then release, then game_won.
  - time_left stays 999 throughout the pause.
  - After game_won: won_cnt[2]=1, state_out passes 3 then 5.
- In PLAY, game_won=game_lost=1 in the same cycle as tick_1s.
  - Next state is LOST; time_left unchanged; won_cnt unchanged.
- level_sel=4 with N_LEVELS=3, and level_sel=0: state stays MENU and all outputs remain 0.
- CNT_W=2, run 5 wins on level 1.
  - won_cnt[0]=3, saturated.
  - retry returns to MENU with the counter retained.
  - rst mid-PLAY clears everything.
